// File: rtl/act_unit_scheduler.sv
// act_unit_scheduler: streams a latched z vector through one shared
// activation unit and gathers the returned activations into a vector.
module act_unit_scheduler #(
   parameter int N_NEURONS   = 4,
   parameter int DATA_W      = 8,
   parameter int ACT_LATENCY = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [N_NEURONS*DATA_W-1:0] in_z,
   output logic                        act_valid,
   output logic [DATA_W-1:0]           act_z,
   input  logic [DATA_W-1:0]           act_a,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [N_NEURONS*DATA_W-1:0] out_a,
   output logic                        busy
);

   localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                      state;
   state_t                      state_nxt;
   logic [IDX_W-1:0]            idx;
   logic [N_NEURONS*DATA_W-1:0] z_q;
   logic [DATA_W-1:0]           z_sel;
   logic                        cap_v;
   logic [IDX_W-1:0]            cap_idx;
   logic                        cap_last;

   always_comb begin
      z_sel = '0;
      for (int i = 0; i < N_NEURONS; i++) begin
         if (idx == IDX_W'(i)) z_sel = z_q[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      act_valid = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_nxt = ISSUE;
         end
         ISSUE: begin
            act_valid = 1'b1;
            if (idx == LAST_IDX) begin
               state_nxt = (ACT_LATENCY > 0) ? DRAIN : DONE;
            end
         end
         DRAIN: begin
            if (cap_v && cap_last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign act_z = act_valid ? z_sel : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         z_q   <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && in_valid) begin
            z_q <= in_z;
            idx <= '0;
         end else if (state == ISSUE) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
         end
      end
   end

   // Each issued slot index travels alongside the activation unit latency
   generate
      if (ACT_LATENCY == 0) begin : g_comb
         assign cap_v   = act_valid;
         assign cap_idx = idx;
      end else begin : g_pipe
         logic [ACT_LATENCY-1:0] pv;
         logic [IDX_W-1:0]       pidx [ACT_LATENCY];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pv <= '0;
               for (int i = 0; i < ACT_LATENCY; i++) pidx[i] <= '0;
            end else begin
               pv[0]   <= act_valid;
               pidx[0] <= idx;
               for (int i = 1; i < ACT_LATENCY; i++) begin
                  pv[i]   <= pv[i-1];
                  pidx[i] <= pidx[i-1];
               end
            end
         end

         assign cap_v   = pv[ACT_LATENCY-1];
         assign cap_idx = pidx[ACT_LATENCY-1];
      end
   endgenerate

   assign cap_last = (cap_idx == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_a <= '0;
      end else if (cap_v) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            if (cap_idx == IDX_W'(i)) out_a[i*DATA_W +: DATA_W] <= act_a;
         end
      end
   end

endmodule

// File: tb/tb_act_unit_scheduler.sv
// tb_act_unit_scheduler: two instances (latency 0 and 3) driven with
// random vectors and checked against a vector-level reference model.
module tb_act_unit_scheduler;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int VW = N * W;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int err = 0;
   int chk = 0;

   logic          iv0, ir0, av0, ov0, or0, bz0;
   logic [VW-1:0] iz0, oa0;
   logic [W-1:0]  az0, aa0;

   logic          iv3, ir3, av3, ov3, or3, bz3;
   logic [VW-1:0] iz3, oa3;
   logic [W-1:0]  az3, aa3;
   logic [W-1:0]  d1, d2, d3;

   // shared unit models: arithmetic halving, and identity after 3 cycles
   assign aa0 = {az0[W-1], az0[W-1:1]};

   always @(posedge clk) begin
      d1 <= av3 ? az3 : '0;
      d2 <= d1;
      d3 <= d2;
   end
   assign aa3 = d3;

   act_unit_scheduler #(.N_NEURONS(N), .DATA_W(W), .ACT_LATENCY(0)) dut0 (
      .clk(clk), .rst(rst),
      .in_valid(iv0), .in_ready(ir0), .in_z(iz0),
      .act_valid(av0), .act_z(az0), .act_a(aa0),
      .out_valid(ov0), .out_ready(or0), .out_a(oa0),
      .busy(bz0)
   );

   act_unit_scheduler #(.N_NEURONS(N), .DATA_W(W), .ACT_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst),
      .in_valid(iv3), .in_ready(ir3), .in_z(iz3),
      .act_valid(av3), .act_z(az3), .act_a(aa3),
      .out_valid(ov3), .out_ready(or3), .out_a(oa3),
      .busy(bz3)
   );

   function automatic logic [W-1:0] lane(input logic [VW-1:0] v, input int i);
      return v[i*W +: W];
   endfunction

   function automatic logic [VW-1:0] half_vec(input logic [VW-1:0] z);
      logic [VW-1:0] r;
      int            s;
      r = '0;
      for (int i = 0; i < N; i++) begin
         s = $signed(lane(z, i));
         s = (s < 0) ? -((-s + 1) / 2) : s / 2;
         r[i*W +: W] = W'(s);
      end
      return r;
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk++;
         if ({ir0, bz0, ov0, av0, az0, oa0} !== {4'b1000, 8'h00, 32'h0}) begin
            err++;
            $display("FAIL reset_idle0 c=%0d: got %b %b %b %b %h %h", c,
                     ir0, bz0, ov0, av0, az0, oa0);
         end
         chk++;
         if ({ir3, bz3, ov3, av3, az3, oa3} !== {4'b1000, 8'h00, 32'h0}) begin
            err++;
            $display("FAIL reset_idle3 c=%0d: got %b %b %b %b %h %h", c,
                     ir3, bz3, ov3, av3, az3, oa3);
         end
      end
   endtask

   task automatic run_vec0(input logic [VW-1:0] z, input string nm);
      chk++;
      if (ir0 !== 1'b1) begin
         err++;
         $display("FAIL %s_ready: got %b want 1", nm, ir0);
      end
      iv0 = 1'b1;
      iz0 = z;
      @(negedge clk);
      iv0 = 1'b0;
      iz0 = ~z;
      for (int i = 0; i < N; i++) begin
         chk++;
         if ({av0, az0, ov0} !== {1'b1, lane(z, i), 1'b0}) begin
            err++;
            $display("FAIL %s_issue%0d: got v=%b z=%h ov=%b want v=1 z=%h ov=0",
                     nm, i, av0, az0, ov0, lane(z, i));
         end
         @(negedge clk);
      end
      chk++;
      if ({ov0, ir0, bz0, av0} !== 4'b1010) begin
         err++;
         $display("FAIL %s_done: got ov/ir/busy/av=%b%b%b%b want 1010",
                  nm, ov0, ir0, bz0, av0);
      end
      chk++;
      if (oa0 !== half_vec(z)) begin
         err++;
         $display("FAIL %s_out_a: got %h want %h", nm, oa0, half_vec(z));
      end
      @(negedge clk);
      chk++;
      if ({ov0, ir0, bz0} !== 3'b010 || oa0 !== half_vec(z)) begin
         err++;
         $display("FAIL %s_after: got ov/ir/busy=%b%b%b out_a=%h want 010 %h",
                  nm, ov0, ir0, bz0, oa0, half_vec(z));
      end
   endtask

   task automatic test_lat0;
      run_vec0(32'h40F01002, "lat0_fixed");
      for (int t = 0; t < 3; t++) run_vec0($urandom, "lat0_rand");
   endtask

   task automatic test_lat3(input logic [VW-1:0] z);
      chk++;
      if (ir3 !== 1'b1) begin
         err++;
         $display("FAIL lat3_ready: got %b want 1", ir3);
      end
      iv3 = 1'b1;
      iz3 = z;
      @(negedge clk);
      iv3 = 1'b0;
      iz3 = ~z;
      for (int i = 0; i < N; i++) begin
         chk++;
         if ({av3, az3, ov3} !== {1'b1, lane(z, i), 1'b0}) begin
            err++;
            $display("FAIL lat3_issue%0d: got v=%b z=%h ov=%b want v=1 z=%h ov=0",
                     i, av3, az3, ov3, lane(z, i));
         end
         @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
         chk++;
         if ({av3, az3, ov3, bz3} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
            err++;
            $display("FAIL lat3_drain%0d: got v=%b z=%h ov=%b busy=%b", i,
                     av3, az3, ov3, bz3);
         end
         @(negedge clk);
      end
      chk++;
      if ({ov3, ir3} !== 2'b10 || oa3 !== z) begin
         err++;
         $display("FAIL lat3_done: got ov=%b ir=%b out_a=%h want 1 0 %h",
                  ov3, ir3, oa3, z);
      end
      @(negedge clk);
      chk++;
      if ({ov3, ir3, bz3} !== 3'b010) begin
         err++;
         $display("FAIL lat3_after: got ov/ir/busy=%b%b%b want 010", ov3, ir3, bz3);
      end
   endtask

   task automatic test_backpressure;
      logic [VW-1:0] z1, z2;
      z1 = $urandom;
      z2 = ~z1 ^ 32'h0F0F_3C3C;
      or0 = 1'b0;
      iv0 = 1'b1;
      iz0 = z1;
      @(negedge clk);
      iz0 = z2;
      repeat (N) @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         chk++;
         if ({ov0, ir0, av0} !== 3'b100 || oa0 !== half_vec(z1)) begin
            err++;
            $display("FAIL stall c=%0d: got ov/ir/av=%b%b%b out_a=%h want 100 %h",
                     c, ov0, ir0, av0, oa0, half_vec(z1));
         end
         @(negedge clk);
      end
      or0 = 1'b1;
      @(negedge clk);
      chk++;
      if ({ov0, ir0} !== 2'b01) begin
         err++;
         $display("FAIL stall_release: got ov=%b ir=%b want 0 1", ov0, ir0);
      end
      run_vec0(z2, "stall_next");
   endtask

   task automatic test_reset_mid;
      logic [VW-1:0] z;
      z = $urandom;
      iv0 = 1'b1;
      iz0 = z;
      @(negedge clk);
      iv0 = 1'b0;
      repeat (2) @(negedge clk);
      chk++;
      if ({av0, az0} !== {1'b1, lane(z, 2)}) begin
         err++;
         $display("FAIL mid_idx2: got v=%b z=%h want 1 %h", av0, az0, lane(z, 2));
      end
      rst = 1'b1;
      #1;
      chk++;
      if ({ir0, bz0, ov0, av0, az0, oa0} !== {4'b1000, 8'h00, 32'h0}) begin
         err++;
         $display("FAIL mid_reset: got %b %b %b %b %h %h",
                  ir0, bz0, ov0, av0, az0, oa0);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk++;
         if ({ov0, bz0, av0} !== 3'b000) begin
            err++;
            $display("FAIL mid_quiet c=%0d: got ov/busy/av=%b%b%b want 000",
                     c, ov0, bz0, av0);
         end
      end
      run_vec0($urandom, "mid_next");
   endtask

   task automatic test_back_to_back;
      logic [VW-1:0] pend[$];
      int            last;
      int            nacc;
      int            nout;
      bit            chg;
      last = -1;
      nacc = 0;
      nout = 0;
      chg  = 1'b0;
      or0  = 1'b1;
      iv0  = 1'b1;
      iz0  = $urandom;
      for (int c = 0; c < 40; c++) begin
         if (ov0 === 1'b1) begin
            chk++;
            if (pend.size() == 0) begin
               err++;
               $display("FAIL b2b_spurious c=%0d: out_valid with nothing pending", c);
            end else begin
               if (oa0 !== half_vec(pend[0])) begin
                  err++;
                  $display("FAIL b2b_out c=%0d: got %h want %h", c, oa0,
                           half_vec(pend[0]));
               end
               void'(pend.pop_front());
            end
            nout++;
         end
         if (ir0 === 1'b1) begin
            if (last >= 0) begin
               chk++;
               if (c - last != N + 2) begin
                  err++;
                  $display("FAIL b2b_gap: got %0d want %0d", c - last, N + 2);
               end
            end
            last = c;
            pend.push_back(iz0);
            nacc++;
            chg = 1'b1;
         end
         @(negedge clk);
         if (chg) begin
            iz0 = $urandom;
            chg = 1'b0;
         end
      end
      iv0 = 1'b0;
      repeat (6) @(negedge clk);
      chk++;
      if (nacc != 7 || nout != 6) begin
         err++;
         $display("FAIL b2b_count: got acc=%0d out=%0d want 7 6", nacc, nout);
      end
   endtask

   initial begin
      rst = 1'b1;
      iv0 = 1'b0;
      iz0 = '0;
      or0 = 1'b1;
      iv3 = 1'b0;
      iz3 = '0;
      or3 = 1'b1;
      test_reset();
      test_lat0();
      test_lat3(32'h40F01002);
      for (int t = 0; t < 3; t++) test_lat3($urandom);
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", err, chk);
      $finish;
   end

endmodule

// File: doc/act_unit_scheduler.md
Name: act_unit_scheduler

Overview:
- Time-multiplexes one shared LUT-plus-interpolation activation unit across all neurons of a layer.
- Accepts one layer's vector of N signed pre-activation values (z) on a valid/ready handshake.
- Issues the z values to the shared activation datapath one per cycle and collects the activations a into an output vector.
- Presents the output vector on a valid/ready handshake. Sits between the layer's MAC/accumulate stage and the next layer's input.

Parameters:
- N_NEURONS, 4, number of neurons (z values) per vector; >= 1.
- DATA_W, 8, width of each signed z and a value.
- ACT_LATENCY, 0, cycles from act_z issue to a valid act_a. 0 means combinational, captured in the issue cycle. Range 0..7.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream z vector valid.
- in_ready  output  1  block can accept a vector.
- in_z  input  N_NEURONS*DATA_W  packed signed z values; neuron i at bits [i*DATA_W +: DATA_W].
- act_valid  output  1  act_z carries a value being issued this cycle.
- act_z  output  DATA_W  signed z to the shared activation unit.
- act_a  input  DATA_W  signed activation returned by the shared unit.
- out_valid  output  1  out_a holds a complete activation vector.
- out_ready  input  1  downstream accepts out_a.
- out_a  output  N_NEURONS*DATA_W  packed signed activations, same packing as in_z.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, immediate on rst high): state=IDLE, issue index=0, capture pipeline cleared, z latch=0, out_a=0. Outputs: out_valid=0, act_valid=0, act_z=0, busy=0, in_ready=1.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1: latch in_z whole, set issue index=0, go to ISSUE.
  - in_z is not sampled at any other time.
- ISSUE:
  - act_valid=1 and act_z = latched z[idx].
  - idx increments each cycle, from 0 to N_NEURONS-1.
  - On the last index: go to DRAIN if ACT_LATENCY>0, else to DONE.
  - act_z=0 whenever act_valid=0.
- Capture:
  - Each issue pushes (valid, idx) into an ACT_LATENCY-deep shift pipeline.
  - When the pipeline output is valid, act_a is written to out_a slot idx at that rising edge.
  - With ACT_LATENCY=0, act_a is captured at the rising edge ending the issue cycle.
- DRAIN:
  - act_valid=0.
  - Go to DONE at the edge that captures index N_NEURONS-1.
- DONE:
  - out_valid=1 and out_a is held stable.
  - Go to IDLE on a rising edge with out_ready=1; out_valid drops the next cycle.
  - out_a keeps its last value after the handshake.
- Timing: input accepted at edge k gives issues in cycles k+1..k+N_NEURONS. out_valid first goes high in cycle k+N_NEURONS+ACT_LATENCY+1.
- No overlap between vectors: in_ready=0 in ISSUE, DRAIN and DONE. Throughput is one vector per N_NEURONS+ACT_LATENCY+2 cycles when out_ready is held high.
- act_a is treated as opaque DATA_W bits: no sign extension, saturation or reordering.
- Backpressure: out_ready low in DONE stalls indefinitely with out_a and out_valid stable. in_valid held high meanwhile is not accepted.
- N_NEURONS=1: ISSUE lasts exactly one cycle.
- Reset mid-operation discards the in-flight vector and any partially captured activations. No out_valid is produced for it.
- Index and pipeline counters are sized to ceil(log2(N_NEURONS)) and ceil(log2(ACT_LATENCY+1)) bits, minimum 1 bit.

Test Plan:
- Reset, then hold rst=0 with no stimulus -> in_ready=1, busy=0, out_valid=0, act_valid=0, act_z=0, out_a=0 on every cycle.
- N=4, LAT=0, activation model a=z>>>1, in_z={8'h40,8'hF0,8'h10,8'h02} accepted at edge k:
  - act_z = 02,10,F0,40 in cycles k+1..k+4.
  - out_valid high at cycle k+5.
  - out_a = {8'h20,8'hF8,8'h08,8'h01}.
- N=4, LAT=3, model a=z delayed 3 cycles, same in_z:
  - act_valid high only in cycles k+1..k+4.
  - out_valid first high at cycle k+8.
  - out_a equals in_z.
- Hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> out_a and out_valid stable, in_ready=0, no new accept. Set out_ready=1 -> IDLE next cycle, then the new vector is accepted.
- Assert rst for 1 cycle during ISSUE at idx=2 -> outputs go to reset values immediately, and no out_valid for that vector. The next vector then completes with correct values.
- Back-to-back vectors with out_ready=1 and in_valid=1 held, LAT=0 -> one accept every 6 cycles (N+LAT+2), each out_a correct.
